// File: rtl/msi_pkg.sv
// MSI encodings, bus op encodings and the snoop FSM state type.
// Shared with the CPU-request MSI controller.
package msi_pkg;

  localparam logic [1:0] MSI_INVALID  = 2'b00;
  localparam logic [1:0] MSI_MODIFIED = 2'b01;
  localparam logic [1:0] MSI_SHARED   = 2'b10;
  localparam logic [1:0] MSI_ERROR    = 2'b11;

  localparam logic [1:0] BUS_INVALIDATE = 2'b00;
  localparam logic [1:0] BUS_WRITE_MISS = 2'b01;
  localparam logic [1:0] BUS_READ_MISS  = 2'b10;
  localparam logic [1:0] BUS_ILLEGAL    = 2'b11;

  typedef enum logic [1:0] {
    SNP_IDLE    = 2'd0,
    SNP_EVAL    = 2'd1,
    SNP_WB      = 2'd2,
    SNP_RESPOND = 2'd3
  } snoop_state_e;

  typedef struct packed {
    logic       wr;
    logic       wb;
    logic       err;
    logic [1:0] next;
  } snoop_action_t;

  // Snoop reaction for one latched request; a miss or an INVALID line leaves everything untouched.
  function automatic snoop_action_t snoop_decide(input logic [1:0] op,
                                                 input logic       hit,
                                                 input logic [1:0] line);
    snoop_action_t act;
    act = '0;
    if (hit && line != MSI_INVALID) begin
      if (line == MSI_ERROR || op == BUS_ILLEGAL) begin
        act.err = 1'b1;
      end else if (line == MSI_SHARED) begin
        if (op != BUS_READ_MISS) begin
          act.wr   = 1'b1;
          act.next = MSI_INVALID;
        end
      end else if (op == BUS_READ_MISS) begin
        act.wr   = 1'b1;
        act.wb   = 1'b1;
        act.next = MSI_SHARED;
      end else if (op == BUS_WRITE_MISS) begin
        act.wr   = 1'b1;
        act.wb   = 1'b1;
        act.next = MSI_INVALID;
      end else begin
        act.err = 1'b1;
      end
    end
    return act;
  endfunction

endpackage

// File: rtl/msi_wb_burst.sv
// Dirty-block write-back streamer: walks the data array one word per
// accepted handshake and flags the final word.
module msi_wb_burst #(
  parameter int unsigned WORD_WIDTH      = 32,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_wb_ready,
  input  logic [WORD_WIDTH-1:0] i_rd_word,
  output logic [IDX_W-1:0]      o_rd_idx,
  output logic                  o_wb_valid,
  output logic [WORD_WIDTH-1:0] o_wb_data,
  output logic                  o_wb_last,
  output logic                  o_done
);

  logic             r_active;
  logic [IDX_W-1:0] r_cnt;
  logic             w_valid;
  logic             w_fire;
  logic             w_last;

  assign w_valid = r_active && !rst;
  assign w_fire  = w_valid && i_wb_ready;
  assign w_last  = (r_cnt == IDX_W'(WORDS_PER_BLOCK - 1));

  // Counter only moves on a handshake, so data/index/last hold through stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
    end else if (w_fire) begin
      if (w_last) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + IDX_W'(1);
      end
    end
  end

  assign o_rd_idx   = rst ? '0 : r_cnt;
  assign o_wb_valid = w_valid;
  assign o_wb_data  = w_valid ? i_rd_word : '0;
  assign o_wb_last  = w_valid && w_last;
  assign o_done     = w_fire && w_last;

endmodule

// File: rtl/msi_bus_snoop_controller.sv
// Snoop-side MSI controller: reacts to other cores' bus requests against the
// local line, flushing a MODIFIED block before committing the new state.
module msi_bus_snoop_controller
  import msi_pkg::*;
#(
  parameter int unsigned WORD_WIDTH      = 32,
  parameter int unsigned WORDS_PER_BLOCK = 4,
  parameter int unsigned IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  snoop_valid,
  output logic                  snoop_ready,
  input  logic [1:0]            snoop_op,
  input  logic                  snoop_hit,
  input  logic [1:0]            line_state_in,
  output logic [IDX_W-1:0]      data_rd_idx,
  input  logic [WORD_WIDTH-1:0] data_rd_word,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [WORD_WIDTH-1:0] wb_data,
  output logic                  wb_last,
  output logic                  abort_mem_access,
  output logic                  state_wr_en,
  output logic [1:0]            state_next,
  output logic                  snoop_done,
  output logic                  snoop_error
);

  snoop_state_e  r_state;
  snoop_state_e  w_state_nxt;
  logic [1:0]    r_op;
  logic          r_hit;
  logic [1:0]    r_line;
  snoop_action_t r_act;
  snoop_action_t w_eval;
  logic          w_accept;
  logic          w_burst_start;
  logic          w_burst_done;

  assign w_eval = snoop_decide(r_op, r_hit, r_line);

  // State register plus request latch and the decision made in EVAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SNP_IDLE;
      r_op    <= '0;
      r_hit   <= 1'b0;
      r_line  <= '0;
      r_act   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op   <= snoop_op;
        r_hit  <= snoop_hit;
        r_line <= line_state_in;
      end
      if (r_state == SNP_EVAL) begin
        r_act <= w_eval;
      end
    end
  end

  // Next state and control outputs; everything is forced low while rst is high.
  always_comb begin
    w_state_nxt      = r_state;
    snoop_ready      = 1'b0;
    w_accept         = 1'b0;
    w_burst_start    = 1'b0;
    abort_mem_access = 1'b0;
    snoop_done       = 1'b0;
    state_wr_en      = 1'b0;
    state_next       = MSI_INVALID;
    snoop_error      = 1'b0;
    if (!rst) begin
      case (r_state)
        SNP_IDLE: begin
          snoop_ready = 1'b1;
          w_accept    = snoop_valid;
          if (snoop_valid) begin
            w_state_nxt = SNP_EVAL;
          end
        end
        SNP_EVAL: begin
          abort_mem_access = w_eval.wb;
          w_burst_start    = w_eval.wb;
          w_state_nxt      = w_eval.wb ? SNP_WB : SNP_RESPOND;
        end
        SNP_WB: begin
          abort_mem_access = 1'b1;
          if (w_burst_done) begin
            w_state_nxt = SNP_RESPOND;
          end
        end
        SNP_RESPOND: begin
          abort_mem_access = r_act.wb;
          snoop_done       = 1'b1;
          state_wr_en      = r_act.wr;
          state_next       = r_act.wr ? r_act.next : MSI_INVALID;
          snoop_error      = r_act.err;
          w_state_nxt      = SNP_IDLE;
        end
        default: w_state_nxt = SNP_IDLE;
      endcase
    end
  end

  msi_wb_burst #(
    .WORD_WIDTH     (WORD_WIDTH),
    .WORDS_PER_BLOCK(WORDS_PER_BLOCK),
    .IDX_W          (IDX_W)
  ) u_wb_burst (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_burst_start),
    .i_wb_ready(wb_ready),
    .i_rd_word (data_rd_word),
    .o_rd_idx  (data_rd_idx),
    .o_wb_valid(wb_valid),
    .o_wb_data (wb_data),
    .o_wb_last (wb_last),
    .o_done    (w_burst_done)
  );

endmodule
